// File: rtl/decode_stage_pipe.sv
// RV32I decode stage: control/immediate decode, register file with writeback
// bypass, load-use bubble insertion and the ID/EX pipeline register.
module decode_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            ex_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] data_a,
    output logic [XLEN-1:0] data_b,
    output logic [XLEN-1:0] imm,
    output logic [AW-1:0]   rd,
    output logic [6:0]      funct7,
    output logic [2:0]      funct3,
    output logic [1:0]      crt_wb,
    output logic [2:0]      crt_mem,
    output logic [2:0]      crt_exe,
    output logic            illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [XLEN-1:0] regs [NREG];

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd_d;
    logic [1:0]      wb_d;
    logic [2:0]      mem_d;
    logic [2:0]      exe_d;
    logic            ill_d;
    logic            uses_rs2;
    logic            is_lui;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rdata_a;
    logic [XLEN-1:0] rdata_b;
    logic            hazard;

    assign opcode = instr[6:0];
    assign rd_d   = instr[7 +: AW];
    assign rs2    = instr[20 +: AW];
    assign rs1    = is_lui ? '0 : instr[15 +: AW];

    always_comb begin
        wb_d     = 2'b00;
        mem_d    = 3'b000;
        exe_d    = 3'b000;
        ill_d    = 1'b0;
        uses_rs2 = 1'b0;
        is_lui   = 1'b0;
        imm32    = 32'h0;
        case (opcode)
            OP_R: begin
                wb_d     = 2'b01;
                exe_d    = 3'b100;
                uses_rs2 = 1'b1;
            end
            OP_I: begin
                wb_d  = 2'b01;
                exe_d = 3'b101;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                wb_d  = 2'b11;
                mem_d = 3'b010;
                exe_d = 3'b001;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                mem_d    = 3'b100;
                exe_d    = 3'b001;
                uses_rs2 = 1'b1;
                imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                mem_d    = 3'b001;
                exe_d    = 3'b010;
                uses_rs2 = 1'b1;
                imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI: begin
                wb_d   = 2'b01;
                exe_d  = 3'b001;
                is_lui = 1'b1;
                imm32  = {instr[31:12], 12'h000};
            end
            default: ill_d = 1'b1;
        endcase
    end

    // Widen by replicating bit 31 so any XLEN >= 32 works without zero-width replication
    always_comb begin
        imm_d       = {XLEN{imm32[31]}};
        imm_d[31:0] = imm32;
    end

    always_comb begin
        rdata_a = regs[rs1];
        if (wb_we && (wb_addr == rs1)) rdata_a = wb_data;
        if (rs1 == '0) rdata_a = '0;
        rdata_b = regs[rs2];
        if (wb_we && (wb_addr == rs2)) rdata_b = wb_data;
        if (rs2 == '0) rdata_b = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wb_we && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign hazard = in_valid & out_valid & crt_mem[1] & (rd != '0) &
                    ((rd == rs1) | ((rd == rs2) & uses_rs2));
    assign in_ready = ~ex_stall & ~hazard;

    // Stall outranks flush: the redirect source keeps flush high until it lands
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_a    <= '0;
            data_b    <= '0;
            imm       <= '0;
            rd        <= '0;
            funct7    <= '0;
            funct3    <= '0;
            crt_wb    <= '0;
            crt_mem   <= '0;
            crt_exe   <= '0;
            illegal   <= 1'b0;
        end else if (ex_stall) begin
            out_valid <= out_valid;
        end else if (flush || hazard || !in_valid) begin
            out_valid <= 1'b0;
            crt_wb    <= '0;
            crt_mem   <= '0;
            crt_exe   <= '0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            data_a    <= rdata_a;
            data_b    <= rdata_b;
            imm       <= imm_d;
            rd        <= rd_d;
            funct7    <= instr[31:25];
            funct3    <= instr[14:12];
            crt_wb    <= wb_d;
            crt_mem   <= mem_d;
            crt_exe   <= exe_d;
            illegal   <= ill_d;
        end
    end

endmodule
